// File: rtl/tb_periph_pkg.sv
// Shared definitions for the testbench pseudo-peripheral AXI4-Lite slave:
// register offsets, AXI response codes, FSM state types and window decode.
package tb_periph_pkg;

  localparam logic [4:0] OFF_PRINT  = 5'h00;
  localparam logic [4:0] OFF_EXIT   = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CYC_LO = 5'h0C;
  localparam logic [4:0] OFF_CYC_HI = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // True when addr falls inside the 32-byte window starting at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return (addr & 32'hFFFF_FFE0) == (base & 32'hFFFF_FFE0);
  endfunction

endpackage

// File: rtl/tb_cycle_counter.sv
// Free-running 64-bit cycle counter. A LO read raises snap_i, which copies
// the upper half into a shadow so the following HI read is coherent.
module tb_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [63:0] cnt_q;
  logic [31:0] shadow_q;

  // Count every cycle (wrapping naturally) and capture the upper half on a LO read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (snap_i) shadow_q <= cnt_q[63:32];
    end
  end

  assign lo_o = cnt_q[31:0];
  assign hi_o = shadow_q;

endmodule

// File: rtl/axi_lite_tb_periph.sv
// AXI4-Lite slave exposing the testbench pseudo-peripherals: stdout character
// port, exit register, test-status register and a 64-bit cycle counter.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where both valid and ready are high; a source holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module axi_lite_tb_periph
  import tb_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] print_wdata_o,
  output logic        print_valid_o,
  output logic [31:0] exit_value_o,
  output logic        exit_valid_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o
);

  // live_q keeps every ready low while reset is asserted.
  logic        live_q;
  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [7:0]  print_char_q;
  logic        print_valid_q;
  logic [31:0] exit_value_q, status_q;
  logic        exit_valid_q, passed_q, failed_q;

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp, rd_resp;
  logic        do_print, do_exit, do_status, snap;
  logic [31:0] rd_data, cyc_lo, cyc_hi;

  assign s_awready = live_q && (wr_state_q == W_IDLE) && !aw_held_q;
  assign s_wready  = live_q && (wr_state_q == W_IDLE) && !w_held_q;
  assign s_arready = live_q && (rd_state_q == R_IDLE);
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign ar_hs     = s_arvalid && s_arready;

  // A channel arriving this cycle counts as held, so AW+W together respond next cycle.
  assign wr_addr = aw_held_q ? awaddr_q : s_awaddr;
  assign wr_data = w_held_q  ? wdata_q  : s_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : s_wstrb;
  assign wr_fire = (wr_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // Write FSM: collect AW and W in any order, then hold B until accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    s_bvalid   = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (wr_fire) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write decode: response code and which side effect the completed write triggers.
  always_comb begin
    wr_resp   = RESP_SLVERR;
    do_print  = 1'b0;
    do_exit   = 1'b0;
    do_status = 1'b0;
    if (in_window(wr_addr, BASE_ADDR)) begin
      case (wr_addr[4:0])
        OFF_PRINT: begin
          wr_resp  = RESP_OKAY;
          do_print = wr_strb[0];
        end
        OFF_EXIT: if (wr_strb == 4'hF) begin
          wr_resp = RESP_OKAY;
          do_exit = 1'b1;
        end
        OFF_STATUS: if (wr_strb == 4'hF) begin
          wr_resp   = RESP_OKAY;
          do_status = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read FSM: accept AR when idle, then hold R until accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    s_rvalid   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: if (ar_hs) rd_state_d = R_DATA;
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read decode: registers are sampled before any same-cycle write lands.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    snap    = 1'b0;
    if (in_window(s_araddr, BASE_ADDR)) begin
      case (s_araddr[4:0])
        OFF_PRINT:  rd_resp = RESP_OKAY;
        OFF_EXIT:   begin rd_resp = RESP_OKAY; rd_data = exit_value_q; end
        OFF_STATUS: begin rd_resp = RESP_OKAY; rd_data = status_q; end
        OFF_CYC_LO: begin rd_resp = RESP_OKAY; rd_data = cyc_lo; snap = ar_hs; end
        OFF_CYC_HI: begin rd_resp = RESP_OKAY; rd_data = cyc_hi; end
        default: ;
      endcase
    end
  end

  // State registers, channel capture and peripheral side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      wr_state_q    <= W_IDLE;
      rd_state_q    <= R_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      print_char_q  <= '0;
      print_valid_q <= 1'b0;
      exit_value_q  <= '0;
      exit_valid_q  <= 1'b0;
      status_q      <= '0;
      passed_q      <= 1'b0;
      failed_q      <= 1'b0;
    end else begin
      live_q        <= 1'b1;
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      print_valid_q <= wr_fire && do_print;
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
      if (wr_fire) begin
        bresp_q <= wr_resp;
        if (do_print) print_char_q <= wr_data[7:0];
        if (do_exit) begin
          exit_value_q <= wr_data;
          exit_valid_q <= 1'b1;
        end
        if (do_status) begin
          status_q <= wr_data;
          if (wr_data == PASS_MAGIC) passed_q <= 1'b1;
          if (wr_data == FAIL_MAGIC) failed_q <= 1'b1;
        end
      end
    end
  end

  tb_cycle_counter u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .snap_i (snap),
    .lo_o   (cyc_lo),
    .hi_o   (cyc_hi)
  );

  assign s_bresp        = s_bvalid ? bresp_q : RESP_OKAY;
  assign s_rdata        = rdata_q;
  assign s_rresp        = rresp_q;
  assign print_wdata_o  = {24'b0, print_char_q};
  assign print_valid_o  = print_valid_q;
  assign exit_value_o   = exit_value_q;
  assign exit_valid_o   = exit_valid_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;

endmodule

// File: doc/axi_lite_tb_periph.md
Name: axi_lite_tb_periph

Overview:
AXI4-Lite slave implementing the testbench pseudo-peripherals inside the AXI subsystem: stdout character port, exit register, test-status register and a free-running cycle counter. It sits between the subsystem's AXI interconnect and the testbench top. It produces print_wdata/print_valid, exit_value/exit_valid and tests_passed/tests_failed, which the top consumes to print characters and end simulation. One outstanding write and one outstanding read at a time; the read and write channels are independent.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 32-byte peripheral window; only addr[31:5] is compared.
PASS_MAGIC, 32'd123456789, status write value that sets tests_passed_o.
FAIL_MAGIC, 32'd1, status write value that sets tests_failed_o.

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_awaddr  in  32  write address
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  32  write data
s_wstrb  in  4  write strobes
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_araddr  in  32  read address
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  R valid
s_rready  in  1  R ready
print_wdata_o  out  32  character in bits [7:0], upper bits zero
print_valid_o  out  1  one-cycle pulse per character
exit_value_o  out  32  latched exit code
exit_valid_o  out  1  sticky exit flag
tests_passed_o  out  1  sticky pass flag
tests_failed_o  out  1  sticky fail flag

Behaviour:
- Reset and clock: rst_n asynchronous, active-low; clock clk. While rst_n is low, every output is 0 (ready, valid, resp, data and flags all zero). In-flight transactions are dropped.
- Register map (offset = addr[4:0]):
  - 0x00 PRINT, write-only.
  - 0x04 EXIT, read/write.
  - 0x08 STATUS, read/write; reads the last written value.
  - 0x0C CYCLE_LO, read-only.
  - 0x10 CYCLE_HI, read-only.
  - Any other offset, or addr[31:5] != BASE_ADDR[31:5]: SLVERR (2'b10); reads return 0; no side effect.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, s_awready = !aw_held and s_wready = !w_held. AW and W can arrive in either order or in the same cycle; each is latched on its handshake.
  - When both are held, the side effect executes in that same cycle, then the FSM goes to W_RESP with s_bvalid = 1 on the next edge.
  - In W_RESP, s_awready and s_wready are 0 and B is held stable until s_bready. Then go to W_IDLE and clear the held flags.
  - Latency: AW+W together -> bvalid 1 cycle later.
- Write side effects (evaluated on the cycle both AW and W are held):
  - PRINT: needs s_wstrb[0]. print_valid_o pulses high for exactly 1 cycle (the next cycle) with print_wdata_o = {24'b0, wdata[7:0]}. If wstrb[0] = 0: OKAY, no pulse.
  - EXIT: needs wstrb = 4'hF, else SLVERR and no effect. exit_value_o <= wdata, exit_valid_o <= 1 (sticky). A second write updates the value; the flag stays 1.
  - STATUS: needs wstrb = 4'hF, else SLVERR. Store wdata. If equal to PASS_MAGIC, set tests_passed_o; if equal to FAIL_MAGIC, set tests_failed_o. Other values store only. The flags are sticky and both can end up set.
  - CYCLE_LO/HI: writes give SLVERR.
- Read FSM, states R_IDLE and R_DATA:
  - s_arready = 1 in R_IDLE. On handshake, capture rdata/rresp and go to R_DATA.
  - In R_DATA, s_rvalid = 1 and data is held stable until s_rready, then return to R_IDLE. Latency is 1 cycle.
- Cycle counter:
  - 64-bit, increments every clk after reset and wraps 2^64-1 -> 0.
  - A CYCLE_LO read snapshots bits [63:32] into a shadow register. CYCLE_HI returns the shadow, so a LO-then-HI read pair is coherent.
- Concurrency:
  - A simultaneous read and write of EXIT/STATUS returns the pre-write value.
  - A read during a pending B is allowed.

Decomposition:
- Package tb_periph_pkg holds:
  - Offset localparams OFF_PRINT/OFF_EXIT/OFF_STATUS/OFF_CYC_LO/OFF_CYC_HI.
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - wr_state_e {W_IDLE, W_RESP} and rd_state_e {R_IDLE, R_DATA}.
- One sub-module, tb_cycle_counter: 64-bit counter with LO-read snapshot shadow and 32-bit LO/HI read outputs.

Test Plan:
- Write 0x48 with wstrb 4'h1 to PRINT, AW and W in the same cycle -> print_valid_o high exactly 1 cycle with print_wdata_o = 0x48; bvalid 1 cycle later with bresp 00.
- W 3 cycles before AW, writing PASS_MAGIC to STATUS -> s_wready low after the W handshake; tests_passed_o = 1 and stays 1; STATUS read returns 0x075BCD15.
- Write 0x7 to EXIT with s_bready held low for 5 cycles -> exit_valid_o = 1, exit_value_o = 7; bvalid stays high and the next awready stays low until bready.
- Read offset 0x14 and write an address outside the window -> rresp = 10 with rdata = 0; bresp = 10; no output changes.
- Read CYCLE_LO then CYCLE_HI with the counter forced near 0x0000_0000_FFFF_FFFE -> HI equals the value snapshotted at the LO read; a combined value that steps backward across the carry is a failure.
- Assert rst_n low while in W_RESP and R_DATA -> all outputs are 0 immediately; after release, new transactions complete normally.
